control_sequencer: RTL
======================

// Module: control_sequencer
// PURPOSE
//   Hardwired control unit that drives the Datapath's bus/register strobes,
//   replacing hand-sequenced test stimulus. Fetches each instruction
//   (T0-T2), decodes IR, and runs 3-register ALU ops (T3-T5): R[ra] <= R[rb] op R[rc].
//   Sits upstream of Datapath: consumes IR contents and memory ready, emits
//   every control strobe Datapath accepts.
// PARAMETERS
//   NUM_REGS   16  general registers; width of one-hot Rout/Rin
//   REG_SEL_W  4   register-field width in IR
//   OPC_W      5   opcode field width, IR[31:27]
// PORTS
//   clk        in   1   system clock; all state changes on rising edge
//   clr        in   1   asynchronous, active-low reset
//   start      in   1   level; leave IDLE/HALT and begin fetching
//   mem_ready  in   1   memory data valid on Mdatain this cycle
//   ir         in   32  Datapath IR output
//   PCout, Zlowout, MDRout, MARin, Zin, PCin, MDRin, IRin, Yin, IncPC, Read
//              out  1   Datapath strobes, same meaning as Datapath ports
//   ADD, SUB, AND, OR  out 1  ALU operation select, one-hot or all zero
//   Rout       out  16  one-hot GPR bus drive (bit n -> RnOut)
//   Rin        out  16  one-hot GPR load (bit n -> Rnin)
//   run        out  1   1 while executing (not IDLE/HALT)
//   instr_done out  1   one-cycle pulse in the last state of each instruction
//   illegal_op out  1   one-cycle pulse in T3 on an undefined opcode
// BEHAVIOUR
//   - IR fields: opc=ir[31:27], ra=ir[26:23], rb=ir[22:19], rc=ir[18:15].
//   - Opcodes: ADD=5'd3, SUB=5'd4, AND=5'd5, OR=5'd6, NOP=5'd26, HALT=5'd27.
//     Every other opcode is treated as NOP plus an illegal_op pulse.
//   - Moore outputs, decoded from the registered state only. Every output not
//     listed for a state is 0.
//   - States and transitions (one clk per state unless noted):
//     IDLE: run=0. Go to T0 when start=1.
//     T0: PCout, MARin, IncPC, Zin.
//     T1: Zlowout, PCin, Read, MDRin. Hold T1 while mem_ready=0; PCin/Read/MDRin
//         stay asserted through the wait. Go to T2 on the edge that samples mem_ready=1.
//     T2: MDRout, IRin.
//     T3: decode ir, which is valid here.
//         ALU op: Rout[rb], Yin; next T4.
//         NOP or illegal: instr_done (illegal also pulses illegal_op); next T0.
//         HALT: instr_done; next HALT.
//     T4: Rout[rc], Zin, op strobe from opc latched at T3 in a 4-bit op
//         register; next T5.
//     T5: Zlowout, Rin[ra], instr_done; next T0.
//     HALT: run=0. Go to T0 only on a start rising edge (start was 0 the
//         previous cycle). A start held high does not restart.
//   - Fetch-to-writeback latency for an ALU op: 6 clk with mem_ready tied 1.
//   - ra==rb or ra==rc is legal; Rout and Rin are never asserted in the same state.
//   - start is ignored while run=1.
//   - Reset (clr=0) at any time, including mid-T1 wait: state <= IDLE, op
//     register <= 0, start-edge register <= 0. All outputs go to 0
//     immediately and asynchronously. Nothing resumes until clr=1 and start=1.
// TESTING
//   1. clr=0 pulse, then clr=1, start=0 -> all outputs 0, run=0 for 10 clk.
//   2. start=1, mem_ready=1, ir=32'h20228000 (SUB r0,r4,r5)
//      -> T0..T5 in 6 clk; T3 Rout=16'h0010; T4 Rout=16'h0020 with SUB=1;
//      T5 Rin=16'h0001, instr_done=1.
//   3. ir=32'h18A18000 (ADD r1,r4,r3), mem_ready low for 3 clk in T1
//      -> T1 held 4 clk with Read=1; then T3 Rout[4], T4 Rout[3] with ADD=1,
//      T5 Rin[1].
//   4. ir=32'hF8000000 (opc 31) -> illegal_op and instr_done pulse in T3; next
//      state T0; no Yin, Zin or Rin asserted.
//   5. ir=32'hD8000000 (HALT) with start held 1 -> run=0, stays in HALT; start
//      0 then 1 -> T0.
//   6. clr=0 asserted mid-T4 -> all outputs 0 before next clk edge; after
//      release, IDLE until start.

Source files
------------

// File: rtl/control_sequencer.sv
// control_sequencer: hardwired fetch/decode/execute control unit driving Datapath strobes
module control_sequencer #(
  parameter int NUM_REGS  = 16,
  parameter int REG_SEL_W = 4,
  parameter int OPC_W     = 5
) (
  input  logic                clk,
  input  logic                clr,
  input  logic                start,
  input  logic                mem_ready,
  input  logic [31:0]         ir,
  output logic                PCout,
  output logic                Zlowout,
  output logic                MDRout,
  output logic                MARin,
  output logic                Zin,
  output logic                PCin,
  output logic                MDRin,
  output logic                IRin,
  output logic                Yin,
  output logic                IncPC,
  output logic                Read,
  output logic                ADD,
  output logic                SUB,
  output logic                AND,
  output logic                OR,
  output logic [NUM_REGS-1:0] Rout,
  output logic [NUM_REGS-1:0] Rin,
  output logic                run,
  output logic                instr_done,
  output logic                illegal_op
);
  typedef enum logic [2:0] {IDLE, T0, T1, T2, T3, T4, T5, HALT} state_t;
  localparam logic [OPC_W-1:0] OPC_ADD  = OPC_W'(3);
  localparam logic [OPC_W-1:0] OPC_SUB  = OPC_W'(4);
  localparam logic [OPC_W-1:0] OPC_AND  = OPC_W'(5);
  localparam logic [OPC_W-1:0] OPC_OR   = OPC_W'(6);
  localparam logic [OPC_W-1:0] OPC_NOP  = OPC_W'(26);
  localparam logic [OPC_W-1:0] OPC_HALT = OPC_W'(27);
  localparam logic [NUM_REGS-1:0] ONE = NUM_REGS'(1);
  state_t state_q, state_d;
  logic [3:0] op_q, op_d;
  logic start_q;
  logic [OPC_W-1:0] opc;
  logic [REG_SEL_W-1:0] ra, rb, rc;
  logic [3:0] op_dec;
  logic is_alu, is_halt, is_nop;
  logic unused_ir;
  assign opc = ir[31 -: OPC_W];
  assign ra = ir[31-OPC_W -: REG_SEL_W];
  assign rb = ir[31-OPC_W-REG_SEL_W -: REG_SEL_W];
  assign rc = ir[31-OPC_W-2*REG_SEL_W -: REG_SEL_W];
  assign unused_ir = &{1'b0, ir[31-OPC_W-3*REG_SEL_W:0]};
  assign op_dec = {opc == OPC_OR, opc == OPC_AND, opc == OPC_SUB, opc == OPC_ADD};
  assign is_alu = |op_dec;
  assign is_halt = opc == OPC_HALT;
  assign is_nop = opc == OPC_NOP;
  always_comb begin
    state_d = state_q;
    op_d = op_q;
    {PCout, Zlowout, MDRout, MARin, Zin, PCin, MDRin, IRin, Yin, IncPC, Read,
     ADD, SUB, AND, OR, instr_done, illegal_op} = 17'b0;
    Rout = '0;
    Rin = '0;
    run = (state_q != IDLE) && (state_q != HALT);
    case (state_q)
      IDLE: state_d = start ? T0 : IDLE;
      T0: begin
        {PCout, MARin, IncPC, Zin} = 4'hf;
        state_d = T1;
      end
      T1: begin
        {Zlowout, PCin, Read, MDRin} = 4'hf;
        state_d = mem_ready ? T2 : T1;
      end
      T2: begin
        {MDRout, IRin} = 2'b11;
        state_d = T3;
      end
      T3: begin
        op_d = op_dec;
        Rout = is_alu ? ONE << rb : '0;
        Yin = is_alu;
        instr_done = !is_alu;
        illegal_op = !is_alu && !is_nop && !is_halt;
        state_d = is_alu ? T4 : (is_halt ? HALT : T0);
      end
      T4: begin
        Rout = ONE << rc;
        Zin = 1'b1;
        {OR, AND, SUB, ADD} = op_q;
        state_d = T5;
      end
      T5: begin
        Zlowout = 1'b1;
        Rin = ONE << ra;
        instr_done = 1'b1;
        state_d = T0;
      end
      HALT: state_d = (start && !start_q) ? T0 : HALT;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q <= IDLE;
      op_q <= '0;
      start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q <= op_d;
      start_q <= start;
    end
  end
endmodule
